mux_scan_ctrl: RTL and testbench

//   Upstream sequencer and downstream collector for the 8:1 single-bit mux.
//   - Drives the mux select through channels 0..7.
//   - Holds each channel for DWELL cycles so the path settles.
//   - Samples the returned mux bit and assembles the eight samples into a parallel byte.
//   - Flags the byte with a one-cycle valid pulse.

---
 rtl/mux_scan_ctrl_if.sv | 20 ++
 rtl/mux_scan_ctrl.sv | 99 +++++++++
 tb/tb_mux_scan_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mux_scan_ctrl_if.sv
// rtl/mux_scan_ctrl_if.sv - control/data bundle between the scan controller and its mux/consumer side
interface mux_scan_ctrl_if;
    logic       start;
    logic       auto;
    logic       mux_out;
    logic [2:0] sel;
    logic [7:0] data;
    logic       valid;
    logic       busy;

    modport master (
        output start, auto, mux_out,
        input  sel, data, valid, busy
    );

    modport slave (
        input  start, auto, mux_out,
        output sel, data, valid, busy
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - steps an 8:1 mux select, dwells per channel and gathers samples into a byte
module mux_scan_ctrl #(
    parameter int DWELL = 4
) (
    input  logic           clk,
    input  logic           rst,
    mux_scan_ctrl_if.slave bus
);
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    generate
        if (DWELL < 1) begin : g_bad_dwell
            $error("mux_scan_ctrl: DWELL must be >= 1");
        end
    endgenerate

    typedef enum logic {IDLE, SCAN} state_t;

    state_t           state_q, state_d;
    logic [2:0]       sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       cap_q, cap_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        data_d  = data_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                sel_d  = 3'd0;
                cnt_d  = '0;
                busy_d = 1'b0;
                if (bus.start) begin
                    state_d = SCAN;
                    busy_d  = 1'b1;
                end
            end
            SCAN: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d        = '0;
                    cap_d[sel_q] = bus.mux_out;
                    if (sel_q != 3'd7) begin
                        sel_d = sel_q + 3'd1;
                    end else begin
                        // Channel 7 goes straight into data; its capture slot is not read back.
                        data_d  = {bus.mux_out, cap_q[6:0]};
                        valid_d = 1'b1;
                        sel_d   = 3'd0;
                        if (!bus.auto) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = 3'd0;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 3'd0;
            cnt_q   <= '0;
            cap_q   <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.sel   = sel_q;
    assign bus.data  = data_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - directed vector bench for mux_scan_ctrl with DWELL=4
module tb_mux_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_pat = 8'h00;
    int         checks = 0;
    int         errors = 0;

    mux_scan_ctrl_if bus ();

    mux_scan_ctrl #(.DWELL(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.mux_out = in_pat[bus.sel];

    typedef struct {
        logic [7:0] pa;
        logic [7:0] pb;
        int         sw;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Single scan: start sampled at E0, pattern switched to pb just after edge E0+sw (sw=0: never).
    task automatic do_scan(input logic [7:0] pa, input logic [7:0] pb, input int sw,
                           output int lat, output bit seq_ok);
        logic [7:0] old_data;
        logic [2:0] exp_sel;
        in_pat   = pa;
        old_data = bus.data;
        lat      = -1;
        seq_ok   = 1'b1;
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        if (bus.busy !== 1'b1 || bus.sel !== 3'd0) seq_ok = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (n == sw) in_pat = pb;
            exp_sel = (n < 32) ? 3'(n / 4) : 3'd0;
            if (bus.sel !== exp_sel) seq_ok = 1'b0;
            if (bus.valid === 1'b1) begin
                lat = n;
                break;
            end
            if (bus.data !== old_data || bus.busy !== 1'b1) seq_ok = 1'b0;
        end
    endtask

    initial begin
        int  lat;
        bit  ok;
        int  nv;
        bit  busy_drop;
        bit  extra;

        vecs[0] = '{pa: 8'hAA, pb: 8'hAA, sw: 0,  exp_data: 8'hAA};
        vecs[1] = '{pa: 8'h00, pb: 8'h00, sw: 0,  exp_data: 8'h00};
        vecs[2] = '{pa: 8'hFF, pb: 8'hFF, sw: 0,  exp_data: 8'hFF};
        vecs[3] = '{pa: 8'h01, pb: 8'h01, sw: 0,  exp_data: 8'h01};
        vecs[4] = '{pa: 8'h80, pb: 8'h80, sw: 0,  exp_data: 8'h80};
        vecs[5] = '{pa: 8'hAA, pb: 8'h3C, sw: 16, exp_data: 8'h3A};
        vecs[6] = '{pa: 8'h3C, pb: 8'hAA, sw: 8,  exp_data: 8'hA8};

        bus.start = 1'b0;
        bus.auto  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_sel",   32'(bus.sel),   0);
        check("reset_data",  32'(bus.data),  0);
        check("reset_valid", 32'(bus.valid), 0);
        check("reset_busy",  32'(bus.busy),  0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            do_scan(vecs[i].pa, vecs[i].pb, vecs[i].sw, lat, ok);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32);
            check($sformatf("vec%0d_sequence", i), 32'(ok), 1);
            check($sformatf("vec%0d_data", i), 32'(bus.data), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_busy_at_valid", i), 32'(bus.busy), 0);
            @(posedge clk); #1;
            check($sformatf("vec%0d_valid_one_cycle", i), 32'(bus.valid), 0);
            check($sformatf("vec%0d_data_hold", i), 32'(bus.data), 32'(vecs[i].exp_data));
        end

        // auto=1 in IDLE alone must not start anything
        bus.auto = 1'b1;
        extra = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.busy !== 1'b0 || bus.valid !== 1'b0) extra = 1'b1;
        end
        check("auto_idle_no_start", 32'(extra), 0);

        // Back-to-back scans in auto mode; auto dropped during the second scan
        in_pat = 8'hAA;
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        nv = 0;
        busy_drop = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (bus.valid === 1'b1) begin
                nv++;
                if (nv == 1) begin
                    check("auto_first_latency", 32'(n), 32);
                    check("auto_first_data", 32'(bus.data), 32'h AA);
                    check("auto_busy_kept", 32'(bus.busy), 1);
                    check("auto_sel_wrap", 32'(bus.sel), 0);
                    in_pat   = 8'h55;
                    bus.auto = 1'b0;
                end else begin
                    check("auto_second_latency", 32'(n), 64);
                    check("auto_second_data", 32'(bus.data), 32'h55);
                    check("auto_end_busy", 32'(bus.busy), 0);
                    break;
                end
            end else if (bus.busy !== 1'b1) begin
                busy_drop = 1'b1;
            end
        end
        check("auto_two_valids", 32'(nv), 2);
        check("auto_no_busy_gap", 32'(busy_drop), 0);

        // start re-pulsed mid-scan and again on the completion edge: both dropped
        in_pat = 8'hC3;
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        nv = 0;
        lat = -1;
        for (int n = 1; n <= 80; n++) begin
            if (n == 10 || n == 32) bus.start = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (bus.valid === 1'b1) begin
                nv++;
                if (lat < 0) lat = n;
            end
            if (n > 32 && bus.busy !== 1'b0) extra = 1'b1;
        end
        check("restart_latency", 32'(lat), 32);
        check("restart_one_valid", 32'(nv), 1);
        check("restart_no_extra_scan", 32'(extra), 0);
        check("restart_data", 32'(bus.data), 32'hC3);

        // Asynchronous reset mid-scan clears everything before the next edge
        in_pat = 8'h96;
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (17) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_sel",   32'(bus.sel),   0);
        check("midrst_data",  32'(bus.data),  0);
        check("midrst_valid", 32'(bus.valid), 0);
        check("midrst_busy",  32'(bus.busy),  0);
        @(posedge clk); #1 rst = 1'b0;
        do_scan(8'h5A, 8'h5A, 0, lat, ok);
        check("post_rst_latency", 32'(lat), 32);
        check("post_rst_hold_zero", 32'(ok), 1);
        check("post_rst_data", 32'(bus.data), 32'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
